// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder: FSM state encoding,
// saturation limit and channel slice positions within the packed rate bus.
package spike_dec_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Largest value a w-bit spike counter can hold.
    function automatic int unsigned cnt_max(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // LSB position of channel ch inside a packed bus of cnt_w-wide channel slices.
    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned cnt_w);
        return ch * cnt_w;
    endfunction

endpackage

// File: rtl/spike_sat_counter.sv
// Saturating per-channel spike counter with a sticky saturation flag.
// With SPIKE_RATE_DEC_LEAK_EN defined the count halves at window end instead of clearing.
import spike_dec_pkg::*;

module spike_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             clr_or_leak,
    output logic [CNT_W-1:0] cnt,
    output logic             sat
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sat_q, sat_d;

    // cnt/sat already include this cycle's spike, so the snapshot sees it.
    always_comb begin
        cnt = cnt_q;
        sat = sat_q;
        if (inc) begin
            if (cnt_q == CNT_MAX) begin
                sat = 1'b1;
            end else begin
                cnt = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt;
        sat_d = sat;
        if (clr) begin
            cnt_d = '0;
            sat_d = 1'b0;
        end else if (clr_or_leak) begin
`ifdef SPIKE_RATE_DEC_LEAK_EN
            cnt_d = cnt >> 1;
`else
            cnt_d = '0;
`endif
            sat_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sat_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts N_CH spike trains into windowed per-channel rates behind a valid/ready output.
// Optional leaky counting is selected with SPIKE_RATE_DEC_LEAK_EN.
import spike_dec_pkg::*;

module spike_rate_decoder #(
    parameter int N_CH  = 3,
    parameter int WIN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [N_CH-1:0]       spike_in,
    input  logic [WIN_W-1:0]      window_len,
    output logic [N_CH*CNT_W-1:0] rate_out,
    output logic [N_CH-1:0]       overflow,
    output logic                  missed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  window_tick
);

    state_t               state_q;
    logic [WIN_W-1:0]     win_cnt_q;

    logic [N_CH*CNT_W-1:0] rate_q, rate_d;
    logic [N_CH-1:0]       ovf_q, ovf_d;
    logic                  missed_q, missed_d;
    logic                  valid_q, valid_d;

    logic                  len_zero;
    logic                  counting;
    logic                  win_end;
    logic                  cnt_clr;
    logic [N_CH*CNT_W-1:0] final_cnt;
    logic [N_CH-1:0]       final_sat;

    assign len_zero = (window_len == '0);
    assign counting = (state_q == COUNT) && !len_zero && enable;
    // Live equality compare: shrinking window_len below win_cnt waits for the wrap.
    assign win_end  = counting && (win_cnt_q == window_len - 1'b1);
    assign cnt_clr  = (state_q == IDLE) || len_zero;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [CNT_W-1:0] ch_cnt;

            spike_sat_counter #(
                .CNT_W(CNT_W)
            ) u_cnt (
                .clk        (clk),
                .rst_n      (rst_n),
                .clr        (cnt_clr),
                .inc        (counting && spike_in[gi]),
                .clr_or_leak(win_end),
                .cnt        (ch_cnt),
                .sat        (final_sat[gi])
            );

            assign final_cnt[ch_lsb(gi, CNT_W) +: CNT_W] = ch_cnt;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            win_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    win_cnt_q <= '0;
                    if (!len_zero) begin
                        state_q <= COUNT;
                    end
                end
                COUNT: begin
                    if (len_zero) begin
                        state_q   <= IDLE;
                        win_cnt_q <= '0;
                    end else if (enable) begin
                        win_cnt_q <= win_end ? '0 : win_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    win_cnt_q <= '0;
                end
            endcase
        end
    end

    // A snapshot takes priority over a transfer; missed records an unread overwrite.
    always_comb begin
        rate_d   = rate_q;
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        missed_d = missed_q;
        if (win_end) begin
            rate_d   = final_cnt;
            ovf_d    = final_sat;
            valid_d  = 1'b1;
            missed_d = valid_q && !out_ready;
        end else if (valid_q && out_ready) begin
            valid_d  = 1'b0;
            missed_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_q   <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            rate_q   <= rate_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            missed_q <= missed_d;
        end
    end

    assign rate_out    = rate_q;
    assign overflow    = ovf_q;
    assign missed      = missed_q;
    assign out_valid   = valid_q;
    assign window_tick = win_end;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed self-checking bench for spike_rate_decoder (8-bit and 4-bit count instances).
module tb_spike_rate_decoder;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        enable     = 1'b0;
    logic        out_ready  = 1'b0;
    logic [2:0]  spike_in   = 3'b000;
    logic [7:0]  window_len = 8'd0;

    logic [23:0] rate_out;
    logic [2:0]  overflow;
    logic        missed, out_valid, window_tick;

    logic [11:0] rate4;
    logic [2:0]  ovf4;
    logic        missed4, valid4, tick4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    spike_rate_decoder #(.N_CH(3), .WIN_W(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .rate_out(rate_out), .overflow(overflow),
        .missed(missed), .out_valid(out_valid), .out_ready(out_ready),
        .window_tick(window_tick)
    );

    spike_rate_decoder #(.N_CH(3), .WIN_W(8), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .rate_out(rate4), .overflow(ovf4),
        .missed(missed4), .out_valid(valid4), .out_ready(out_ready),
        .window_tick(tick4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0; enable = 1'b0; spike_in = 3'b000; window_len = 8'd0; out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b1; spike_in = 3'b111; window_len = 8'd4; out_ready = 1'b0;
        step();
        step();
        n_checks++;
        if ({rate_out, overflow, missed, out_valid, window_tick} !== 30'd0) begin
            n_fail++;
            $display("FAIL reset_dut8 got=%h required=0", {rate_out, overflow, missed, out_valid, window_tick});
        end
        n_checks++;
        if ({rate4, ovf4, missed4, valid4, tick4} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_dut4 got=%h required=0", {rate4, ovf4, missed4, valid4, tick4});
        end
        $display("test_reset: outputs sampled under reset");
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        apply_reset();
        window_len = 8'd4; enable = 1'b1; out_ready = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            spike_in = {1'b0, (k % 2 == 0), 1'b1};
            #1;
            n_checks++;
            if (window_tick !== (k % 4 == 3)) begin
                n_fail++;
                $display("FAIL basic_tick k=%0d got=%b required=%b", k, window_tick, (k % 4 == 3));
            end
            step();
            if (k % 4 == 3) begin
                n_checks++;
                if ({out_valid, overflow, rate_out} !== {1'b1, 3'b000, 24'h000204}) begin
                    n_fail++;
                    $display("FAIL basic_snapshot k=%0d got valid=%b ovf=%b rate=%h required valid=1 ovf=000 rate=000204",
                             k, out_valid, overflow, rate_out);
                end
                $display("test_basic: window snapshot rate=%h", rate_out);
            end
            if (k % 4 == 0 && k >= 4) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL basic_drain k=%0d got valid=%b required=0", k, out_valid);
                end
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        window_len = 8'd255; enable = 1'b1; out_ready = 1'b1; spike_in = 3'b001;
        step();
        for (int k = 0; k < 255; k++) begin
            step();
            if (k == 253) begin
                n_checks++;
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_early got valid=%b required=0", out_valid);
                end
            end
        end
        n_checks++;
        if ({out_valid, overflow, rate_out} !== {1'b1, 3'b000, 24'h0000ff}) begin
            n_fail++;
            $display("FAIL sat_cnt8 got valid=%b ovf=%b rate=%h required valid=1 ovf=000 rate=0000ff",
                     out_valid, overflow, rate_out);
        end
        n_checks++;
        if ({valid4, ovf4, rate4} !== {1'b1, 3'b001, 12'h00f}) begin
            n_fail++;
            $display("FAIL sat_cnt4 got valid=%b ovf=%b rate=%h required valid=1 ovf=001 rate=00f",
                     valid4, ovf4, rate4);
        end
        $display("test_saturation: 255-cycle window rate8=%h rate4=%h ovf4=%b", rate_out, rate4, ovf4);
        for (int k = 0; k < 10; k++) step();
        window_len = 8'd0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if ({out_valid, window_tick} !== 2'b00) begin
                n_fail++;
                $display("FAIL abort_no_snapshot k=%0d got valid=%b tick=%b required 0 0", k, out_valid, window_tick);
            end
        end
        window_len = 8'd4;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL restart_early k=%0d got valid=%b required=0", k, out_valid);
            end
        end
        step();
        n_checks++;
        if ({out_valid, rate_out, valid4, rate4, ovf4} !== {1'b1, 24'h000004, 1'b1, 12'h004, 3'b000}) begin
            n_fail++;
            $display("FAIL restart_fresh got valid=%b rate=%h valid4=%b rate4=%h ovf4=%b required 1 000004 1 004 000",
                     out_valid, rate_out, valid4, rate4, ovf4);
        end
    endtask

    task automatic test_backpressure();
        apply_reset();
        window_len = 8'd2; enable = 1'b1; out_ready = 1'b0;
        step();
        spike_in = 3'b001;
        step();
        step();
        n_checks++;
        if ({out_valid, missed, rate_out} !== {1'b1, 1'b0, 24'h000002}) begin
            n_fail++;
            $display("FAIL bp_win1 got valid=%b missed=%b rate=%h required 1 0 000002", out_valid, missed, rate_out);
        end
        spike_in = 3'b010;
        step();
        n_checks++;
        if ({out_valid, missed, rate_out} !== {1'b1, 1'b0, 24'h000002}) begin
            n_fail++;
            $display("FAIL bp_hold got valid=%b missed=%b rate=%h required 1 0 000002", out_valid, missed, rate_out);
        end
        step();
        n_checks++;
        if ({out_valid, missed, rate_out} !== {1'b1, 1'b1, 24'h000200}) begin
            n_fail++;
            $display("FAIL bp_win2 got valid=%b missed=%b rate=%h required 1 1 000200", out_valid, missed, rate_out);
        end
        spike_in = 3'b100;
        step();
        spike_in = 3'b000;
        step();
        n_checks++;
        if ({out_valid, missed, overflow, rate_out} !== {1'b1, 1'b1, 3'b000, 24'h010000}) begin
            n_fail++;
            $display("FAIL bp_win3 got valid=%b missed=%b ovf=%b rate=%h required 1 1 000 010000",
                     out_valid, missed, overflow, rate_out);
        end
        $display("test_backpressure: third window rate=%h missed=%b", rate_out, missed);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid, missed} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_transfer got valid=%b missed=%b required 0 0", out_valid, missed);
        end
    endtask

    task automatic test_enable_freeze();
        apply_reset();
        window_len = 8'd4; enable = 1'b1; out_ready = 1'b1; spike_in = 3'b001;
        step();
        step();
        step();
        enable = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_checks++;
            if (window_tick !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_tick k=%0d got=%b required=0", k, window_tick);
            end
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL freeze_valid k=%0d got=%b required=0", k, out_valid);
            end
        end
        enable = 1'b1;
        step();
        #1;
        n_checks++;
        if (window_tick !== 1'b1) begin
            n_fail++;
            $display("FAIL freeze_end_tick got=%b required=1", window_tick);
        end
        step();
        n_checks++;
        if ({out_valid, rate_out} !== {1'b1, 24'h000004}) begin
            n_fail++;
            $display("FAIL freeze_snapshot got valid=%b rate=%h required 1 000004", out_valid, rate_out);
        end
        $display("test_enable_freeze: stretched window rate=%h", rate_out);
    endtask

    task automatic test_async_reset();
        apply_reset();
        window_len = 8'd4; enable = 1'b1; out_ready = 1'b0; spike_in = 3'b001;
        step();
        for (int k = 0; k < 4; k++) step();
        n_checks++;
        if ({out_valid, rate_out} !== {1'b1, 24'h000004}) begin
            n_fail++;
            $display("FAIL areset_pre got valid=%b rate=%h required 1 000004", out_valid, rate_out);
        end
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rate_out, overflow, missed, out_valid, window_tick} !== 30'd0) begin
            n_fail++;
            $display("FAIL areset_async got=%h required=0", {rate_out, overflow, missed, out_valid, window_tick});
        end
        step();
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL areset_early k=%0d got valid=%b required=0", k, out_valid);
            end
        end
        step();
        n_checks++;
        if ({out_valid, rate_out} !== {1'b1, 24'h000004}) begin
            n_fail++;
            $display("FAIL areset_first got valid=%b rate=%h required 1 000004", out_valid, rate_out);
        end
        $display("test_async_reset: first window after release rate=%h", rate_out);
    endtask

    task automatic test_leak();
        logic [7:0] exp_rate [4];
`ifdef SPIKE_RATE_DEC_LEAK_EN
        exp_rate = '{8'd4, 8'd6, 8'd7, 8'd7};
`else
        exp_rate = '{8'd4, 8'd4, 8'd4, 8'd4};
`endif
        apply_reset();
        window_len = 8'd4; enable = 1'b1; out_ready = 1'b1; spike_in = 3'b001;
        step();
        for (int w = 0; w < 4; w++) begin
            for (int k = 0; k < 4; k++) step();
            n_checks++;
            if ({out_valid, rate_out} !== {1'b1, 16'h0000, exp_rate[w]}) begin
                n_fail++;
                $display("FAIL leak_win%0d got valid=%b rate=%h required valid=1 ch0=%0d", w, out_valid, rate_out, exp_rate[w]);
            end
            $display("test_leak: window %0d ch0=%0d", w, rate_out[7:0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_enable_freeze();
        test_async_reset();
        test_leak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
